// File: rtl/g16_div_seq.sv
// Sequential GF(2^4) divider / inverter in the tower normal basis shared with
// G16_mul. Computes z = x * y^14 (= x / y) using one shared multiplier that
// is stepped through a fixed six-product addition chain, with valid/ready
// handshakes on both sides.
module g16_div_seq #(
  parameter logic [3:0] ZERO_RESULT = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_op,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_z,
  output logic       out_dbz
);

  // GF(4) multiply, normal basis (W^2, W): bit 1 = W^2 coeff, bit 0 = W coeff.
  function automatic logic [1:0] g4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // GF(4) scale by N = W^2.
  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  // GF(16) multiply over GF(4), normal basis (Y^4, Y), Y^2 + Y + N = 0.
  function automatic logic [3:0] g16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    logic [1:0] es;
    e  = g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
    es = g4_scl_n(e);
    return {g4_mul(x[3:2], y[3:2]) ^ es, g4_mul(x[1:0], y[1:0]) ^ es};
  endfunction

  // FIN registers the last product onto the output pins, which makes the
  // result visible seven edges after the accept edge.
  typedef enum logic [3:0] {
    IDLE,
    C1,
    C2,
    C3,
    C4,
    C5,
    C6,
    FIN,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic [3:0] t2_q;
  logic [3:0] p_q;
  logic       dbz_q;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [3:0] mul_p;

  assign in_ready = (state == IDLE);

  // Operand selection for the shared multiplier, one chain step per state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      C1: begin mul_a = y_q;  mul_b = y_q;  end  // t2  = y * y
      C2: begin mul_a = p_q;  mul_b = y_q;  end  // t3  = t2 * y
      C3: begin mul_a = p_q;  mul_b = p_q;  end  // t6  = t3 * t3
      C4: begin mul_a = p_q;  mul_b = p_q;  end  // t12 = t6 * t6
      C5: begin mul_a = p_q;  mul_b = t2_q; end  // t14 = t12 * t2
      C6: begin mul_a = x_q;  mul_b = p_q;  end  // z   = x * t14
      default: begin mul_a = '0; mul_b = '0; end
    endcase
  end

  // The single multiplier instance.
  always_comb mul_p = g16_mul(mul_a, mul_b);

  // Control FSM, operand/product registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      t2_q      <= '0;
      p_q       <= '0;
      dbz_q     <= 1'b0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_op ? 4'hF : in_x;
            y_q   <= in_y;
            dbz_q <= (in_y == 4'h0);
            state <= C1;
          end
        end
        C1: begin
          p_q   <= mul_p;
          t2_q  <= mul_p;
          state <= C2;
        end
        C2: begin
          p_q   <= mul_p;
          state <= C3;
        end
        C3: begin
          p_q   <= mul_p;
          state <= C4;
        end
        C4: begin
          p_q   <= mul_p;
          state <= C5;
        end
        C5: begin
          p_q   <= mul_p;
          state <= C6;
        end
        C6: begin
          p_q   <= mul_p;
          state <= FIN;
        end
        FIN: begin
          out_z     <= dbz_q ? ZERO_RESULT : p_q;
          out_dbz   <= dbz_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_g16_div_seq.sv
// Scoreboard bench for g16_div_seq: the driver queues each accepted request,
// the monitor checks every emitted result against a GF(16) model.
module tb_g16_div_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_op = 1'b0;
  logic [3:0] in_x = '0;
  logic [3:0] in_y = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, in_ready_b;
  logic       out_valid, out_valid_b;
  logic [3:0] out_z, out_z_b;
  logic       out_dbz, out_dbz_b;

  g16_div_seq #(.ZERO_RESULT(4'h0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_dbz(out_dbz)
  );

  g16_div_seq #(.ZERO_RESULT(4'hA)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_z(out_z_b), .out_dbz(out_dbz_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       op;
    logic       has_exp;
    logic [3:0] exp_z;
    int         acc;
  } txn_t;

  txn_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_z = '0;
  logic       prev_v = 1'b0;

  // GF(4) by discrete log: 3 = one, 1 = W, 2 = W^2 = N.
  function automatic int lg4(input logic [1:0] a);
    return (a == 2'd3) ? 0 : ((a == 2'd1) ? 1 : 2);
  endfunction
  function automatic logic [1:0] ex4(input int e);
    return (e == 0) ? 2'd3 : ((e == 1) ? 2'd1 : 2'd2);
  endfunction
  function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    return ex4((lg4(a) + lg4(b)) % 3);
  endfunction
  // (aY^4 + bY)(cY^4 + dY): hi = ac + N*s, lo = bd + N*s, s = ac+ad+bc+bd.
  function automatic logic [3:0] mul16(input logic [3:0] p, input logic [3:0] q);
    logic [1:0] a, b, c, d, s;
    a = p[3:2]; b = p[1:0]; c = q[3:2]; d = q[1:0];
    s = m4(2'd2, m4(a, c) ^ m4(a, d) ^ m4(b, c) ^ m4(b, d));
    return {m4(a, c) ^ s, m4(b, d) ^ s};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency on rising out_valid, result check on each transfer.
  always @(negedge clk) begin
    txn_t t;
    logic [3:0] tgt;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid !== out_valid_b) chk("valid_pair", out_valid_b, out_valid);
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else chk("latency_edges", cyc - sb[0].acc, 8);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        t   = sb.pop_front();
        tgt = t.op ? 4'hF : t.x;
        chk("dbz", out_dbz, (t.y == 4'h0));
        chk("dbz_b", out_dbz_b, (t.y == 4'h0));
        if (t.y == 4'h0) begin
          chk("zero_result", out_z, 4'h0);
          chk("zero_result_b", out_z_b, 4'hA);
        end else begin
          chk("model_z_times_y", mul16(out_z, t.y), tgt);
          chk("model_b_times_y", mul16(out_z_b, t.y), tgt);
        end
        if (t.has_exp) chk("directed_z", out_z, t.exp_z);
        last_z = out_z;
      end
      prev_v = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic op,
                       input logic has_exp, input logic [3:0] exp_z);
    txn_t t;
    wait_ready();
    in_valid = 1'b1; in_x = x; in_y = y; in_op = op;
    t.x = x; t.y = y; t.op = op; t.has_exp = has_exp; t.exp_z = exp_z; t.acc = cyc;
    sb.push_back(t);
    tick();
    in_valid = 1'b0;
    in_x = $urandom_range(0, 15);
    in_y = $urandom_range(0, 15);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] zc, first_inv;
    bit         dc;
    int         n;

    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_dbz", out_dbz, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Identity divisor.
    issue(4'h6, 4'hF, 1'b0, 1'b1, 4'h6);
    drain();

    // Abort with reset during C3.
    wait_ready();
    in_valid = 1'b1; in_x = 4'h9; in_y = 4'h4; in_op = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("abort_valid_in_rst", out_valid, 0); end
    rst = 1'b0;
    tick();
    chk("abort_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin chk("abort_no_stale", out_valid, 0); tick(); end

    // Self-division, zero dividend, inversion of one.
    for (int y = 1; y < 16; y++) issue(4'(y), 4'(y), 1'b0, 1'b1, 4'hF);
    issue(4'h0, 4'h7, 1'b0, 1'b1, 4'h0);
    issue(4'h5, 4'hF, 1'b1, 1'b1, 4'hF);
    issue(4'h3, 4'h0, 1'b1, 1'b1, 4'h0);
    drain();

    // Double inversion returns the original value.
    for (int y = 1; y < 16; y++) begin
      issue($urandom_range(0, 15), 4'(y), 1'b1, 1'b0, 4'h0);
      drain();
      first_inv = last_z;
      issue(4'h0, first_inv, 1'b1, 1'b1, 4'(y));
      drain();
    end

    // Exhaustive model check over all dividend/divisor pairs.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        issue(4'(x), 4'(y), 1'b0, 1'b0, 4'h0);
    drain();

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(4'h2, 4'h3, 1'b0, 1'b0, 4'h0);
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    chk("bp_valid_seen", out_valid, 1);
    zc = out_z;
    dc = out_dbz;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_z_hold", out_z, zc);
      chk("bp_dbz_hold", out_dbz, dc);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready_rise", in_ready, 1);
    drain();

    // Busy requests are ignored.
    issue(4'h6, 4'hF, 1'b0, 1'b1, 4'h6);
    tick();
    in_valid = 1'b1; in_x = 4'h3; in_y = 4'h5; in_op = 1'b0;
    repeat (4) tick();
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 12; i++) begin chk("busy_no_second", out_valid, 0); tick(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
